// File: rtl/sdf_delay_line.sv
// ---------------------------------------------------------------------------
// sdf_delay_line
//   Run-time selectable complex-sample delay line for SDF FFT stages.
//   Samples shift through a valid-gated chain (mem[0] is the newest slot).
//   The output is the sample accepted exactly D beats earlier, where D is
//   depth_sel clamped to 1..MAX_DEPTH.
//
//   Handshake: in_valid is a pure shift enable. There is no backpressure;
//   every edge with in_valid=1 accepts in_r/in_i. out_valid qualifies
//   out_r/out_i as real data (fill_cnt >= D) rather than fill.
//
// Parameters
//   DW        : width of each real/imaginary word
//   MAX_DEPTH : number of storage slots (2..256)
//   SEL_W     : width of depth_sel and fill_cnt
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : accept in_r/in_i on this edge
//   in_r, in_i : input sample
//   depth_sel  : delay in accepted beats (clamped 1..MAX_DEPTH)
//   flush      : synchronous clear of the fill count
//   out_r,out_i: delayed sample (combinational mux from registers)
//   out_valid  : delayed sample is real data
//   fill_cnt   : accepted beats since reset/flush, saturating at MAX_DEPTH
//   full       : fill_cnt == MAX_DEPTH
//
// Build option
//   DLY_FLUSH_CLEAR_EN : when defined, flush also zeroes the storage slots
//                        (mem[0] still takes a concurrent sample).
// ---------------------------------------------------------------------------
module sdf_delay_line #(
  parameter int DW        = 19,
  parameter int MAX_DEPTH = 16,
  parameter int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_i,
  input  logic [SEL_W-1:0] depth_sel,
  input  logic             flush,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_i,
  output logic             out_valid,
  output logic [SEL_W-1:0] fill_cnt,
  output logic             full
);

  localparam int IDX_W = $clog2(MAX_DEPTH);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH);

  logic [DW-1:0]    mem_r_q [MAX_DEPTH];
  logic [DW-1:0]    mem_i_q [MAX_DEPTH];
  logic [DW-1:0]    mem_r_d [MAX_DEPTH];
  logic [DW-1:0]    mem_i_d [MAX_DEPTH];
  logic [SEL_W-1:0] fill_q;
  logic [SEL_W-1:0] fill_d;

  logic [SEL_W-1:0] d_eff;
  logic [SEL_W-1:0] d_m1;
  logic [IDX_W-1:0] rd_idx;

  // Effective depth: 0 maps to 1, anything above MAX_DEPTH maps to MAX_DEPTH.
  always_comb begin
    if (depth_sel == '0) begin
      d_eff = SEL_W'(1);
    end else if (depth_sel > MAX_SEL) begin
      d_eff = MAX_SEL;
    end else begin
      d_eff = depth_sel;
    end
  end

  // d_eff - 1 is always below MAX_DEPTH, so the low IDX_W bits suffice.
  assign d_m1   = d_eff - SEL_W'(1);
  assign rd_idx = d_m1[IDX_W-1:0];

  // Next-state storage: shift on accepted beats, optionally clear on flush.
  always_comb begin
    mem_r_d = mem_r_q;
    mem_i_d = mem_i_q;
`ifdef DLY_FLUSH_CLEAR_EN
    if (flush) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        mem_r_d[k] = '0;
        mem_i_d[k] = '0;
      end
    end
`endif
    if (in_valid) begin
      // Older slots take the pre-flush contents only when clearing is off;
      // with clearing on, flush wins for every slot except mem[0].
      for (int k = MAX_DEPTH - 1; k > 0; k--) begin
`ifdef DLY_FLUSH_CLEAR_EN
        if (!flush) begin
          mem_r_d[k] = mem_r_q[k-1];
          mem_i_d[k] = mem_i_q[k-1];
        end
`else
        mem_r_d[k] = mem_r_q[k-1];
        mem_i_d[k] = mem_i_q[k-1];
`endif
      end
      mem_r_d[0] = in_r;
      mem_i_d[0] = in_i;
    end
  end

  // Fill count: flush restarts history; a concurrent sample counts as beat 1.
  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = in_valid ? SEL_W'(1) : '0;
    end else if (in_valid && (fill_q != MAX_SEL)) begin
      fill_d = fill_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        mem_r_q[k] <= '0;
        mem_i_q[k] <= '0;
      end
      fill_q <= '0;
    end else begin
      mem_r_q <= mem_r_d;
      mem_i_q <= mem_i_d;
      fill_q  <= fill_d;
    end
  end

  assign out_r     = mem_r_q[rd_idx];
  assign out_i     = mem_i_q[rd_idx];
  assign out_valid = (fill_q >= d_eff);
  assign fill_cnt  = fill_q;
  assign full      = (fill_q == MAX_SEL);

endmodule

// File: tb/tb_sdf_delay_line.sv
// ---------------------------------------------------------------------------
// tb_sdf_delay_line
//   Bench for sdf_delay_line (DW=19, MAX_DEPTH=16). A history queue of
//   accepted samples (newest first) plus a beat counter model the block;
//   every negedge the DUT outputs are compared against that model. Directed
//   phases pin the model with hand-computed literals, then a random phase
//   exercises stalls, flushes and depth changes.
// ---------------------------------------------------------------------------
module tb_sdf_delay_line;

  localparam int DW        = 19;
  localparam int MAX_DEPTH = 16;
  localparam int SEL_W     = $clog2(MAX_DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic [DW-1:0]    in_r      = '0;
  logic [DW-1:0]    in_i      = '0;
  logic [SEL_W-1:0] depth_sel = SEL_W'(16);
  logic             flush     = 1'b0;
  logic [DW-1:0]    out_r;
  logic [DW-1:0]    out_i;
  logic             out_valid;
  logic [SEL_W-1:0] fill_cnt;
  logic             full;

  sdf_delay_line #(.DW(DW), .MAX_DEPTH(MAX_DEPTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_r      (in_r),
    .in_i      (in_i),
    .depth_sel (depth_sel),
    .flush     (flush),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_valid (out_valid),
    .fill_cnt  (fill_cnt),
    .full      (full)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q[j] is the sample accepted j beats ago ({real, imag}); zero-filled
  // history stands for reset contents.
  logic [2*DW-1:0] exp_q[$];
  int              m_fill;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      for (int j = 0; j < MAX_DEPTH; j++) exp_q.push_back('0);
      m_fill = 0;
    end else begin
      if (flush) begin
`ifdef DLY_FLUSH_CLEAR_EN
        for (int j = 0; j < MAX_DEPTH; j++) exp_q[j] = '0;
`endif
        m_fill = 0;
      end
      if (in_valid) begin
        exp_q.push_front({in_r, in_i});
        void'(exp_q.pop_back());
        if (m_fill < MAX_DEPTH) m_fill++;
      end
    end
  end

  function automatic int eff_depth(input int ds);
    if (ds == 0) return 1;
    if (ds > MAX_DEPTH) return MAX_DEPTH;
    return ds;
  endfunction

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (exp_q.size() == MAX_DEPTH) begin
      int d;
      logic [2*DW-1:0] e;
      d = eff_depth(int'(depth_sel));
      e = exp_q[d-1];
      chk("cyc_out_r", 64'(out_r), 64'(e[2*DW-1:DW]));
      chk("cyc_out_i", 64'(out_i), 64'(e[DW-1:0]));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_fill >= d));
      chk("cyc_fill_cnt", 64'(fill_cnt), 64'(m_fill));
      chk("cyc_full", 64'(full), 64'(m_fill == MAX_DEPTH));
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; they are stable for
  // both the negedge compare and the next rising edge.
  task automatic drive(input logic v, input int r, input int i, input int ds, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_r      = DW'(r);
    in_i      = DW'(i);
    depth_sel = SEL_W'(ds);
    flush     = fl;
    #1;
  endtask

  logic [DW-1:0] stale_exp;

  initial begin
    // ---- reset ----
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_r", 64'(out_r), 64'd0);
    chk("rst_out_i", 64'(out_i), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;

    // ---- continuous fill at depth 16 ----
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, k, -k, 16, 1'b0);
      if (k == 16) chk("fill_k16_valid", 64'(out_valid), 64'd0);
      if (k == 17) begin
        chk("fill_k17_valid", 64'(out_valid), 64'd1);
        chk("fill_k17_r", 64'(out_r), 64'd1);
        chk("fill_k17_i", 64'(out_i), 64'h7FFFF);
      end
      if (k == 20) chk("fill_k20_r", 64'(out_r), 64'd4);
    end

    // ---- stalls at depth 4 ----
    drive(1'b0, 0, 0, 4, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      drive(1'b1, n, 100 + n, 4, 1'b0);
      if (n >= 5) chk("stall_present_r", 64'(out_r), 64'(n - 4));
      drive(1'b0, int'($urandom_range(0, 500)), 0, 4, 1'b0);
      if (n >= 4) chk("stall_hold_r", 64'(out_r), 64'(n - 3));
    end

    // ---- run-time depth change ----
    drive(1'b0, 0, 0, 16, 1'b1);
    for (int k = 1; k <= 16; k++) drive(1'b1, k, int'($urandom_range(0, 1000)), 16, 1'b0);
    drive(1'b0, 0, 0, 3, 1'b0);
    chk("dsel3_r", 64'(out_r), 64'd14);
    chk("dsel3_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("dsel0_r", 64'(out_r), 64'd16);
    drive(1'b0, 0, 0, 31, 1'b0);
    chk("dsel31_r", 64'(out_r), 64'd1);
    chk("dsel31_valid", 64'(out_valid), 64'd1);

    // ---- flush with concurrent sample ----
    drive(1'b1, 'h55, 'h5, 2, 1'b1);
    drive(1'b0, 0, 0, 2, 1'b0);
    chk("flush_fill", 64'(fill_cnt), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 'h66, 'h6, 2, 1'b0);
    drive(1'b0, 0, 0, 2, 1'b0);
    chk("flush2_valid", 64'(out_valid), 64'd1);
    chk("flush2_r", 64'(out_r), 64'h55);
`ifdef DLY_FLUSH_CLEAR_EN
    stale_exp = '0;
`else
    stale_exp = DW'(16);
`endif
    drive(1'b0, 0, 0, 3, 1'b0);
    chk("flush_d3_r", 64'(out_r), 64'(stale_exp));
    chk("flush_d3_valid", 64'(out_valid), 64'd0);

    // ---- saturation ----
    for (int k = 0; k < 40; k++)
      drive(1'b1, int'($urandom_range(0, 2**DW - 1)), int'($urandom_range(0, 2**DW - 1)), 16, 1'b0);
    chk("sat_fill", 64'(fill_cnt), 64'd16);
    chk("sat_full", 64'(full), 64'd1);

    // ---- asynchronous reset between edges ----
    drive(1'b0, 0, 0, 16, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_out_r", 64'(out_r), 64'd0);
    chk("arst_out_i", 64'(out_i), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_fill", 64'(fill_cnt), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    #3;
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, k, k, 16, 1'b0);
      if (k == 16) chk("arst_k16_valid", 64'(out_valid), 64'd0);
      if (k == 17) chk("arst_k17_r", 64'(out_r), 64'd1);
    end

    // ---- random phase ----
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 2**DW - 1)),
            int'($urandom_range(0, 2**DW - 1)),
            (c % 40 < 20) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 16)),
            1'($urandom_range(0, 29) == 0));
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
